// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit-event trace transmitter.
package commit_trace_pkg;

    // Header word bit positions
    localparam int HDR_R_BIT    = 15;
    localparam int HDR_L_BIT    = 14;
    localparam int HDR_S_BIT    = 13;
    localparam int HDR_H_BIT    = 12;
    localparam int HDR_REG_LSB  = 9;
    localparam int HDR_DROP_BIT = 8;
    localparam int HDR_SEQ_LSB  = 0;

    // Flag nibble layout inside a record, same order as header bits [15:12]
    localparam int FLAG_R = 3;
    localparam int FLAG_L = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_H = 0;

    // Number of counter words appended to the halt record
    localparam int HALT_WORDS = 6;

    // One buffered commit record; drop/seq are frozen at capture time
    typedef struct packed {
        logic [3:0]  flags;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic [15:0] addr;
        logic [15:0] mval;
        logic        drop;
        logic [7:0]  seq;
    } trace_entry_t;

    // Serializer states, one per word slot of a record
    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_ADDR,
        S_VAL,
        S_CNT0,
        S_CNT1,
        S_CNT2,
        S_CNT3,
        S_CNT4,
        S_CNT5,
        S_DONE
    } ser_state_t;

    // Header word built from a stored record
    function automatic logic [15:0] make_header(input trace_entry_t e);
        return {e.flags, e.wreg, e.drop, e.seq};
    endfunction

    // 16-bit saturating increment
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/commit_trace_fifo.sv
// Single-clock record FIFO with DEPTH entries (power of two).
module commit_trace_fifo
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    input  trace_entry_t din_i,
    output trace_entry_t dout_o
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; a push into a full FIFO or a pop from an empty one is ignored
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/commit_trace_tx.sv
// Commit-event trace transmitter: captures retire-stage events into a FIFO
// and serializes each record as 16-bit words over a valid/ready stream.
module commit_trace_tx
    import commit_trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_write_i,
    input  logic [2:0]  write_reg_i,
    input  logic [15:0] write_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_data_in_i,
    input  logic [15:0] mem_data_out_i,
    input  logic        halt_i,
    input  logic        icache_req_i,
    input  logic        icache_hit_i,
    input  logic        dcache_req_i,
    input  logic        dcache_hit_i,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [15:0] tx_data_o,
    output logic        overflow_o,
    output logic        done_o
);

    // Capture-side state
    logic        captured_q;
    logic        halt_retry_q;
    logic        drop_pend_q;
    logic        overflow_q;
    logic [7:0]  seq_q;
    logic [15:0] inst_cnt_q, cyc_cnt_q, dhit_cnt_q, ihit_cnt_q, dreq_cnt_q, ireq_cnt_q;

    // Serializer state
    ser_state_t  state_q, state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [15:0] tx_data_q, tx_data_d;
    logic        done_q, done_d;

    // FIFO interface
    logic         fifo_full, fifo_empty, fifo_push, fifo_pop;
    trace_entry_t fifo_din, fifo_dout;

    logic active, ev, ev_halt, ev_drop;

    // Event detection and record assembly for the current cycle
    always_comb begin
        active    = !captured_q;
        ev_halt   = active && (halt_i || halt_retry_q);
        ev        = active && (reg_write_i || mem_read_i || mem_write_i || halt_i || halt_retry_q);
        fifo_push = ev && !fifo_full;
        ev_drop   = ev && fifo_full;
        fifo_din        = '0;
        fifo_din.flags  = {reg_write_i, mem_read_i, mem_write_i, ev_halt};
        fifo_din.wreg   = write_reg_i;
        fifo_din.wdata  = write_data_i;
        fifo_din.addr   = mem_addr_i;
        fifo_din.mval   = mem_read_i ? mem_data_out_i : mem_data_in_i;
        fifo_din.drop   = drop_pend_q;
        fifo_din.seq    = seq_q;
    end

    // Sequence, drop tracking, halt capture and statistics counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            captured_q   <= 1'b0;
            halt_retry_q <= 1'b0;
            drop_pend_q  <= 1'b0;
            overflow_q   <= 1'b0;
            seq_q        <= '0;
            inst_cnt_q   <= '0;
            cyc_cnt_q    <= '0;
            dhit_cnt_q   <= '0;
            ihit_cnt_q   <= '0;
            dreq_cnt_q   <= '0;
            ireq_cnt_q   <= '0;
        end else begin
            if (fifo_push) begin
                seq_q       <= seq_q + 8'd1;
                drop_pend_q <= 1'b0;
                if (ev_halt) begin
                    captured_q   <= 1'b1;
                    halt_retry_q <= 1'b0;
                end
            end
            if (ev_drop) begin
                drop_pend_q <= 1'b1;
                overflow_q  <= 1'b1;
                if (ev_halt) halt_retry_q <= 1'b1;
            end
            if (active) begin
                cyc_cnt_q <= sat_inc(cyc_cnt_q);
                if (reg_write_i || mem_write_i || halt_i) inst_cnt_q <= sat_inc(inst_cnt_q);
                if (dcache_hit_i) dhit_cnt_q <= sat_inc(dhit_cnt_q);
                if (icache_hit_i) ihit_cnt_q <= sat_inc(ihit_cnt_q);
                if (dcache_req_i) dreq_cnt_q <= sat_inc(dreq_cnt_q);
                if (icache_req_i) ireq_cnt_q <= sat_inc(ireq_cnt_q);
            end
        end
    end

    commit_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout)
    );

    // Slot that follows the current one, skipping slots whose flag is clear
    function automatic ser_state_t next_slot(input ser_state_t s, input logic [3:0] f);
        logic has_mem;
        has_mem = f[FLAG_L] || f[FLAG_S];
        case (s)
            S_HDR:   next_slot = f[FLAG_R] ? S_DATA : has_mem ? S_ADDR : f[FLAG_H] ? S_CNT0 : S_IDLE;
            S_DATA:  next_slot = has_mem ? S_ADDR : f[FLAG_H] ? S_CNT0 : S_IDLE;
            S_ADDR:  next_slot = S_VAL;
            S_VAL:   next_slot = f[FLAG_H] ? S_CNT0 : S_IDLE;
            S_CNT0:  next_slot = S_CNT1;
            S_CNT1:  next_slot = S_CNT2;
            S_CNT2:  next_slot = S_CNT3;
            S_CNT3:  next_slot = S_CNT4;
            S_CNT4:  next_slot = S_CNT5;
            default: next_slot = S_IDLE;
        endcase
    endfunction

    // Serializer next state, FIFO pop and the registered word for the next slot
    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_HDR;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                if (tx_ready_i) begin
                    state_d = next_slot(state_q, fifo_dout.flags);
                    if (state_d == S_IDLE) begin
                        fifo_pop = 1'b1;
                        if (fifo_dout.flags[FLAG_H]) state_d = S_DONE;
                    end
                end
            end
        endcase
        tx_valid_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        case (state_d)
            S_HDR:   tx_data_d = make_header(fifo_dout);
            S_DATA:  tx_data_d = fifo_dout.wdata;
            S_ADDR:  tx_data_d = fifo_dout.addr;
            S_VAL:   tx_data_d = fifo_dout.mval;
            S_CNT0:  tx_data_d = inst_cnt_q;
            S_CNT1:  tx_data_d = cyc_cnt_q;
            S_CNT2:  tx_data_d = dhit_cnt_q;
            S_CNT3:  tx_data_d = ihit_cnt_q;
            S_CNT4:  tx_data_d = dreq_cnt_q;
            S_CNT5:  tx_data_d = ireq_cnt_q;
            default: tx_data_d = 16'h0000;
        endcase
    end

    // Serializer state and registered stream outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign overflow_o = overflow_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx with an expected-word scoreboard.
module tb_commit_trace_tx;

    typedef struct packed {
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        logic        mr;
        logic        mw;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] dout;
        logic        hlt;
        logic        ireq;
        logic        ihit;
        logic        dreq;
        logic        dhit;
    } stim_t;

    logic        clk, rst_n;
    logic        reg_write, mem_read, mem_write, halt;
    logic [2:0]  write_reg;
    logic [15:0] write_data, mem_addr, mem_data_in, mem_data_out;
    logic        icache_req, icache_hit, dcache_req, dcache_hit;
    logic        tx_ready;
    logic        tx_valid, overflow, done;
    logic [15:0] tx_data;

    logic [15:0] expq [$];
    int          checks = 0;
    int          errors = 0;
    int          expSeq = 0;
    logic        expDrop = 1'b0;
    logic        randomReady = 1'b0;
    logic        prevStall = 1'b0;
    logic [15:0] prevData = '0;

    commit_trace_tx #(.DEPTH(8)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reg_write_i    (reg_write),
        .write_reg_i    (write_reg),
        .write_data_i   (write_data),
        .mem_read_i     (mem_read),
        .mem_write_i    (mem_write),
        .mem_addr_i     (mem_addr),
        .mem_data_in_i  (mem_data_in),
        .mem_data_out_i (mem_data_out),
        .halt_i         (halt),
        .icache_req_i   (icache_req),
        .icache_hit_i   (icache_hit),
        .dcache_req_i   (dcache_req),
        .dcache_hit_i   (dcache_hit),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .tx_data_o      (tx_data),
        .overflow_o     (overflow),
        .done_o         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every accepted word with the scoreboard and check stall stability
    always @(negedge clk) begin
        logic [15:0] expWord;
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checks++;
                assert (tx_valid === 1'b1 && tx_data === prevData) else begin
                    errors++;
                    $error("[TB] FAIL stall_hold: observed valid=%0b data=%h, expected valid=1 data=%h",
                           tx_valid, tx_data, prevData);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                checks++;
                assert (expq.size() > 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected_word: observed %h, expected no word", tx_data);
                end
                if (expq.size() > 0) begin
                    expWord = expq.pop_front();
                    checks++;
                    assert (tx_data === expWord) else begin
                        errors++;
                        $error("[TB] FAIL word: observed %h, expected %h", tx_data, expWord);
                    end
                end
            end
            prevStall = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            prevData  = tx_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveInputs(input stim_t s);
        reg_write    = s.rw;
        write_reg    = s.wr;
        write_data   = s.wd;
        mem_read     = s.mr;
        mem_write    = s.mw;
        mem_addr     = s.addr;
        mem_data_in  = s.din;
        mem_data_out = s.dout;
        halt         = s.hlt;
        icache_req   = s.ireq;
        icache_hit   = s.ihit;
        dcache_req   = s.dreq;
        dcache_hit   = s.dhit;
    endtask

    // One clock of stimulus; returns 1 time unit after the edge with inputs idle
    task automatic applyStimulus(input stim_t s);
        driveInputs(s);
        @(posedge clk);
        #1;
        driveInputs('0);
        if (randomReady) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0);
    endtask

    // Reference model: header from tracked seq/drop, then payload words in flag order
    task automatic expectRecord(input logic [3:0] f, input logic [2:0] wr, input logic [15:0] wd,
                                input logic [15:0] addr, input logic [15:0] mval);
        logic [7:0] seq8;
        seq8 = 8'(expSeq);
        expq.push_back({f, wr, expDrop, seq8});
        if (f[3]) expq.push_back(wd);
        if (f[2] || f[1]) begin
            expq.push_back(addr);
            expq.push_back(mval);
        end
        expSeq  = (expSeq + 1) % 256;
        expDrop = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expq.size() != 0 || tx_valid === 1'b1) && n < budget) begin
            @(posedge clk);
            #1;
            if (randomReady) tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checks++;
        assert (expq.size() == 0 && tx_valid === 1'b0) else begin
            errors++;
            $error("[TB] FAIL drain_timeout: observed %0d words pending, expected 0", expq.size());
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        driveInputs('0);
        @(posedge clk);
        #1;
        expq.delete();
        expSeq  = 0;
        expDrop = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        stim_t s;
        rst_n    = 1'b0;
        tx_ready = 1'b1;
        driveInputs('0);

        // Reset values
        doReset();
        checkOutput("rst_valid", 16'(tx_valid), 16'd0);
        checkOutput("rst_data", tx_data, 16'h0000);
        checkOutput("rst_overflow", 16'(overflow), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);

        // Single register write
        $display("[TB] single reg write");
        s = '0; s.rw = 1; s.wr = 3; s.wd = 16'h1234;
        expq.push_back(16'h8600); expq.push_back(16'h1234);
        expSeq = 1;
        applyStimulus(s);
        waitDrain(20);
        checkOutput("valid_after_rec", 16'(tx_valid), 16'd0);

        // Load with register write, then store
        $display("[TB] load and store");
        s = '0; s.rw = 1; s.wr = 5; s.wd = 16'hBEEF; s.mr = 1; s.addr = 16'h0040;
        s.dout = 16'hBEEF; s.din = 16'h1111;
        expq.push_back(16'hCA01); expq.push_back(16'hBEEF);
        expq.push_back(16'h0040); expq.push_back(16'hBEEF);
        applyStimulus(s);
        s = '0; s.mw = 1; s.addr = 16'h0042; s.din = 16'h5555; s.dout = 16'h9999;
        expq.push_back(16'h2002); expq.push_back(16'h0042); expq.push_back(16'h5555);
        expSeq = 3;
        applyStimulus(s);
        waitDrain(40);

        // FIFO fill with ready low; ninth record is dropped
        $display("[TB] overflow");
        doReset();
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            s = '0; s.rw = 1; s.wr = 3'(i); s.wd = 16'hA000 + 16'(i);
            if (i < 8) expectRecord(4'b1000, 3'(i), 16'hA000 + 16'(i), 16'h0, 16'h0);
            applyStimulus(s);
            if (i == 7) checkOutput("overflow_at_full", 16'(overflow), 16'd0);
        end
        checkOutput("overflow_after_drop", 16'(overflow), 16'd1);
        expDrop = 1'b1;
        tx_ready = 1'b1;
        waitDrain(200);
        s = '0; s.rw = 1; s.wr = 1; s.wd = 16'hABCD;
        expectRecord(4'b1000, 3'd1, 16'hABCD, 16'h0, 16'h0);
        applyStimulus(s);
        waitDrain(20);
        checkOutput("overflow_sticky", 16'(overflow), 16'd1);

        // Pseudo-random ready with mixed record types
        $display("[TB] random ready");
        randomReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s = '0;
            s.wr = 3'(k); s.wd = 16'($urandom); s.addr = 16'($urandom);
            s.din = 16'($urandom); s.dout = 16'($urandom);
            case (k % 3)
                0: begin s.rw = 1; expectRecord(4'b1000, s.wr, s.wd, 16'h0, 16'h0); end
                1: begin s.mr = 1; expectRecord(4'b0100, s.wr, s.wd, s.addr, s.dout); end
                default: begin s.mw = 1; expectRecord(4'b0010, s.wr, s.wd, s.addr, s.din); end
            endcase
            applyStimulus(s);
            idleCycles(10);
        end
        waitDrain(300);
        randomReady = 1'b0;
        tx_ready = 1'b1;

        // Halt record statistics over 25 cycles
        $display("[TB] halt statistics");
        doReset();
        for (int i = 1; i <= 25; i++) begin
            s = '0;
            if (i <= 20 && (i % 2) == 0) begin
                s.rw = 1; s.wr = 3'(i); s.wd = 16'(i);
                expectRecord(4'b1000, 3'(i), 16'(i), 16'h0, 16'h0);
            end
            if (i == 3 || i == 7 || i == 11 || i == 15) begin s.ireq = 1; s.ihit = 1; end
            if (i == 5) begin s.dreq = 1; s.dhit = 1; end
            if (i == 6) s.dreq = 1;
            if (i == 25) begin
                s.hlt = 1;
                expectRecord(4'b0001, 3'd0, 16'h0, 16'h0, 16'h0);
                expq.push_back(16'd11); expq.push_back(16'd25); expq.push_back(16'd1);
                expq.push_back(16'd4);  expq.push_back(16'd2);  expq.push_back(16'd4);
            end
            applyStimulus(s);
        end
        waitDrain(60);
        checkOutput("done_after_halt", 16'(done), 16'd1);
        for (int i = 0; i < 3; i++) begin
            s = '0; s.rw = 1; s.wr = 2; s.wd = 16'h7777; s.hlt = 1;
            applyStimulus(s);
        end
        idleCycles(5);
        checkOutput("valid_after_done", 16'(tx_valid), 16'd0);
        checkOutput("done_terminal", 16'(done), 16'd1);

        // Reset while the halt record is on its third counter word
        $display("[TB] reset mid-record");
        doReset();
        tx_ready = 1'b0;
        s = '0; s.hlt = 1;
        applyStimulus(s);
        expq.push_back(16'h1000); expq.push_back(16'd1); expq.push_back(16'd1);
        tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        checkOutput("cnt2_valid", 16'(tx_valid), 16'd1);
        checkOutput("cnt2_data", tx_data, 16'h0000);
        checkOutput("cnt2_consumed", 16'(expq.size()), 16'd0);
        doReset();
        checkOutput("midrst_valid", 16'(tx_valid), 16'd0);
        checkOutput("midrst_done", 16'(done), 16'd0);
        checkOutput("midrst_data", tx_data, 16'h0000);
        tx_ready = 1'b1;
        s = '0; s.rw = 1; s.wr = 2; s.wd = 16'h0F0F;
        expq.push_back(16'h8400); expq.push_back(16'h0F0F);
        applyStimulus(s);
        s = '0; s.hlt = 1;
        expq.push_back(16'h1001);
        expq.push_back(16'd2); expq.push_back(16'd2); expq.push_back(16'd0);
        expq.push_back(16'd0); expq.push_back(16'd0); expq.push_back(16'd0);
        applyStimulus(s);
        waitDrain(40);
        checkOutput("done_after_fresh_halt", 16'(done), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
